// File: rtl/snake_body_pkg.sv
// Constants and types shared by the snake body and food blocks: direction codes,
// packed-location layout, cell size and screen limits.
package snake_body_pkg;

    localparam int FIELD_W = 10;
    localparam int W_HI    = 39;
    localparam int H_HI    = 29;
    localparam int X_HI    = 19;
    localparam int Y_HI    = 9;

    localparam int CELL_SIZE    = 16;
    localparam int SCREEN_X_MAX = 624;
    localparam int SCREEN_Y_MAX = 464;

    localparam int LEN_W = 5;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

endpackage

// File: rtl/segment_cell.sv
// One snake body segment: an (x,y) register pair that loads the start position or
// shifts from its predecessor, plus next-head and pixel containment compares.
module segment_cell
    import snake_body_pkg::*;
#(
    parameter int                 CELL   = CELL_SIZE,
    parameter logic [FIELD_W-1:0] INIT_X = '0,
    parameter logic [FIELD_W-1:0] INIT_Y = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_init,
    input  logic               i_shift,
    input  logic [FIELD_W-1:0] i_shift_x,
    input  logic [FIELD_W-1:0] i_shift_y,
    input  logic [FIELD_W-1:0] i_head_x,
    input  logic [FIELD_W-1:0] i_head_y,
    input  logic [FIELD_W-1:0] i_pix_x,
    input  logic [FIELD_W-1:0] i_pix_y,
    output logic [FIELD_W-1:0] o_x,
    output logic [FIELD_W-1:0] o_y,
    output logic               o_head_eq,
    output logic               o_pixel_in
);

    localparam int EW = FIELD_W + 1;

    logic [FIELD_W-1:0] r_x;
    logic [FIELD_W-1:0] r_y;
    logic [EW-1:0]      w_x_end;
    logic [EW-1:0]      w_y_end;

    always_ff @(posedge clk) begin
        if (!rst_n || i_init) begin
            r_x <= INIT_X;
            r_y <= INIT_Y;
        end else if (i_shift) begin
            r_x <= i_shift_x;
            r_y <= i_shift_y;
        end
    end

    // One extra bit so a cell at the right/bottom edge does not wrap its end bound.
    assign w_x_end = {1'b0, r_x} + EW'(CELL);
    assign w_y_end = {1'b0, r_y} + EW'(CELL);

    assign o_x        = r_x;
    assign o_y        = r_y;
    assign o_head_eq  = (r_x == i_head_x) && (r_y == i_head_y);
    assign o_pixel_in = (i_pix_x >= r_x) && ({1'b0, i_pix_x} < w_x_end) &&
                        (i_pix_y >= r_y) && ({1'b0, i_pix_y} < w_y_end);

endmodule

// File: rtl/snake_body.sv
// Snake state: segment history, length, direction, grow request and death, plus the
// packed head bus for the food block and a registered per-pixel body hit flag.
module snake_body
    import snake_body_pkg::*;
#(
    parameter int CELL      = CELL_SIZE,
    parameter int MAX_LEN   = 16,
    parameter int START_LEN = 3,
    parameter int START_X   = 144,
    parameter int START_Y   = 224,
    parameter int X_MAX     = SCREEN_X_MAX,
    parameter int Y_MAX     = SCREEN_Y_MAX
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               update,
    input  logic               start,
    input  logic [1:0]         dir,
    input  logic               dir_valid,
    input  logic               overlap,
    input  logic [FIELD_W-1:0] pixel_x,
    input  logic [FIELD_W-1:0] pixel_y,
    output logic [39:0]        snakehead,
    output logic               body_hit,
    output logic [LEN_W-1:0]   length,
    output logic               dead
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DEAD = 2'd2;

    localparam int                 XW     = FIELD_W + 1;
    localparam logic signed [XW-1:0] CELL_S = XW'(CELL);
    localparam logic signed [XW-1:0] X_LIM  = XW'(X_MAX);
    localparam logic signed [XW-1:0] Y_LIM  = XW'(Y_MAX);

    logic [1:0]         r_state;
    logic [1:0]         r_cur_dir;
    logic [1:0]         r_pend_dir;
    logic               r_grow;
    logic               r_dead;
    logic               r_body_hit;
    logic [LEN_W-1:0]   r_length;

    logic [FIELD_W-1:0] w_seg_x [MAX_LEN];
    logic [FIELD_W-1:0] w_seg_y [MAX_LEN];
    logic [FIELD_W-1:0] w_src_x [MAX_LEN];
    logic [FIELD_W-1:0] w_src_y [MAX_LEN];
    logic [MAX_LEN-1:0] w_head_eq;
    logic [MAX_LEN-1:0] w_pixel_in;
    logic [MAX_LEN-1:0] w_live;
    logic [MAX_LEN-1:0] w_cmp;

    logic signed [XW-1:0] w_base_x, w_base_y, w_nx, w_ny;
    logic [FIELD_W-1:0]   w_nh_x, w_nh_y;
    logic [LEN_W-1:0]     w_cmp_len;
    logic                 w_run, w_move, w_wall, w_self, w_growing, w_shift;

    // Signed 11-bit arithmetic so stepping off the top/left edge shows up as negative.
    assign w_base_x = signed'({1'b0, w_seg_x[0]});
    assign w_base_y = signed'({1'b0, w_seg_y[0]});

    always_comb begin
        w_nx = w_base_x;
        w_ny = w_base_y;
        case (r_pend_dir)
            DIR_UP:   w_ny = w_base_y - CELL_S;
            DIR_DOWN: w_ny = w_base_y + CELL_S;
            DIR_LEFT: w_nx = w_base_x - CELL_S;
            default:  w_nx = w_base_x + CELL_S;
        endcase
    end

    assign w_nh_x    = w_nx[FIELD_W-1:0];
    assign w_nh_y    = w_ny[FIELD_W-1:0];
    assign w_wall    = (w_nx < 0) || (w_nx > X_LIM) || (w_ny < 0) || (w_ny > Y_LIM);
    assign w_run     = (r_state == ST_RUN);
    assign w_move    = w_run && update && !start;
    assign w_growing = r_grow && (r_length < LEN_W'(MAX_LEN));
    // The tail cell vacates on a normal move, so it only blocks the head when growing.
    assign w_cmp_len = w_growing ? r_length : r_length - LEN_W'(1);
    assign w_self    = |(w_head_eq & w_cmp);
    assign w_shift   = w_move && !w_wall && !w_self;

    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_seg
            if (gi == 0) begin : g_head
                assign w_src_x[gi] = w_nh_x;
                assign w_src_y[gi] = w_nh_y;
            end else begin : g_body
                assign w_src_x[gi] = w_seg_x[gi-1];
                assign w_src_y[gi] = w_seg_y[gi-1];
            end

            assign w_live[gi] = (LEN_W'(gi) < r_length);
            assign w_cmp[gi]  = (LEN_W'(gi) < w_cmp_len);

            segment_cell #(
                .CELL   (CELL),
                .INIT_X (FIELD_W'(START_X - gi * CELL)),
                .INIT_Y (FIELD_W'(START_Y))
            ) u_cell (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_init     (start),
                .i_shift    (w_shift),
                .i_shift_x  (w_src_x[gi]),
                .i_shift_y  (w_src_y[gi]),
                .i_head_x   (w_nh_x),
                .i_head_y   (w_nh_y),
                .i_pix_x    (pixel_x),
                .i_pix_y    (pixel_y),
                .o_x        (w_seg_x[gi]),
                .o_y        (w_seg_y[gi]),
                .o_head_eq  (w_head_eq[gi]),
                .o_pixel_in (w_pixel_in[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n || start) begin
            r_state    <= rst_n ? ST_RUN : ST_IDLE;
            r_cur_dir  <= DIR_RIGHT;
            r_pend_dir <= DIR_RIGHT;
            r_grow     <= 1'b0;
            r_length   <= LEN_W'(START_LEN);
            r_dead     <= 1'b0;
            r_body_hit <= 1'b0;
        end else begin
            r_body_hit <= (r_state != ST_IDLE) && |(w_pixel_in & w_live);
            if (w_run) begin
                if (dir_valid && (dir != (r_cur_dir ^ 2'b01))) begin
                    r_pend_dir <= dir;
                end
                if (update) begin
                    r_grow <= overlap;
                    if (w_wall || w_self) begin
                        r_state <= ST_DEAD;
                        r_dead  <= 1'b1;
                    end else begin
                        r_cur_dir <= r_pend_dir;
                        if (w_growing) begin
                            r_length <= r_length + LEN_W'(1);
                        end
                    end
                end else if (overlap) begin
                    r_grow <= 1'b1;
                end
            end
        end
    end

    assign snakehead[W_HI -: FIELD_W] = FIELD_W'(CELL);
    assign snakehead[H_HI -: FIELD_W] = FIELD_W'(CELL);
    assign snakehead[X_HI -: FIELD_W] = w_seg_x[0];
    assign snakehead[Y_HI -: FIELD_W] = w_seg_y[0];
    assign length   = r_length;
    assign dead     = r_dead;
    assign body_hit = r_body_hit;

endmodule

// File: tb/tb_snake_body.sv
// Bench for snake_body: a move table, then hand sequences for growth, walls,
// self-collision, start priority, reset and the pixel hit test.
module tb_snake_body;

    localparam bit H = 1'b1;
    localparam bit L = 1'b0;
    localparam logic [1:0] UP = 2'b00;
    localparam logic [1:0] DN = 2'b01;
    localparam logic [1:0] LT = 2'b10;
    localparam logic [1:0] RT = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       update = 1'b0;
    logic       start = 1'b0;
    logic [1:0] dir = 2'b00;
    logic       dir_valid = 1'b0;
    logic       overlap = 1'b0;
    logic [9:0] pixel_x = 10'd0;
    logic [9:0] pixel_y = 10'd0;
    logic [39:0] snakehead;
    logic        body_hit;
    logic [4:0]  length;
    logic        dead;

    always #5 clk = ~clk;

    snake_body dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .update    (update),
        .start     (start),
        .dir       (dir),
        .dir_valid (dir_valid),
        .overlap   (overlap),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .snakehead (snakehead),
        .body_hit  (body_hit),
        .length    (length),
        .dead      (dead)
    );

    typedef struct {
        string name;
        int    x;
        int    y;
        int    len;
        bit    dead;
    } exp_t;

    typedef struct {
        string      name;
        bit         upd;
        bit         st;
        bit         dv;
        logic [1:0] d;
        bit         ov;
        int         x;
        int         y;
        int         len;
        bit         dead;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[12];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [39:0] got, input logic [39:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic drive(input bit upd, input bit st, input bit dv, input logic [1:0] d, input bit ov);
        @(negedge clk);
        update    = upd;
        start     = st;
        dir_valid = dv;
        dir       = d;
        overlap   = ov;
        @(posedge clk);
        #1;
        update    = 1'b0;
        start     = 1'b0;
        dir_valid = 1'b0;
        overlap   = 1'b0;
    endtask

    task automatic pop_check();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue, expected a pending entry");
            return;
        end
        e = exp_q.pop_front();
        $display("txn %-16s head=(%0d,%0d) len=%0d dead=%0b", e.name,
                 snakehead[19:10], snakehead[9:0], length, dead);
        check({e.name, " head"}, snakehead, {10'd16, 10'd16, 10'(e.x), 10'(e.y)});
        check({e.name, " length"}, 40'(length), 40'(e.len));
        check({e.name, " dead"}, 40'(dead), 40'(e.dead));
    endtask

    task automatic step(input string name, input bit upd, input bit st, input bit dv,
                        input logic [1:0] d, input bit ov,
                        input int x, input int y, input int len, input bit dd);
        exp_q.push_back('{name, x, y, len, dd});
        drive(upd, st, dv, d, ov);
        pop_check();
    endtask

    task automatic hit_check(input string name, input int px, input int py, input bit want);
        @(negedge clk);
        pixel_x = 10'(px);
        pixel_y = 10'(py);
        @(posedge clk);
        #1;
        $display("txn %-16s pixel=(%0d,%0d) body_hit=%0b", name, px, py, body_hit);
        check(name, 40'(body_hit), 40'(want));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{"start",       L, H, L, UP, L, 144, 224, 3, L};
        tbl[1]  = '{"move1",       H, L, L, UP, L, 160, 224, 3, L};
        tbl[2]  = '{"move2",       H, L, L, UP, L, 176, 224, 3, L};
        tbl[3]  = '{"move3",       H, L, L, UP, L, 192, 224, 3, L};
        tbl[4]  = '{"req_reverse", L, L, H, LT, L, 192, 224, 3, L};
        tbl[5]  = '{"rev_ignored", H, L, L, UP, L, 208, 224, 3, L};
        tbl[6]  = '{"req_up",      L, L, H, UP, L, 208, 224, 3, L};
        tbl[7]  = '{"move_up",     H, L, L, UP, L, 208, 208, 3, L};
        tbl[8]  = '{"overlap",     L, L, L, UP, H, 208, 208, 3, L};
        tbl[9]  = '{"grow_ov_same",H, L, L, UP, H, 208, 192, 4, L};
        tbl[10] = '{"grow_again",  H, L, L, UP, L, 208, 176, 5, L};
        tbl[11] = '{"no_grow",     H, L, L, UP, L, 208, 160, 5, L};

        // Reset with a pixel over the head: IDLE must keep body_hit low.
        pixel_x = 10'd150;
        pixel_y = 10'd230;
        repeat (3) @(posedge clk);
        #1;
        check("reset head", snakehead, {10'd16, 10'd16, 10'd144, 10'd224});
        check("reset length", 40'(length), 40'd3);
        check("reset dead", 40'(dead), 40'd0);
        check("reset body_hit", 40'(body_hit), 40'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("idle_update", H, L, L, UP, L, 144, 224, 3, L);
        hit_check("idle_hit_forced0", 150, 230, L);

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].name, tbl[i].upd, tbl[i].st, tbl[i].dv, tbl[i].d, tbl[i].ov,
                 tbl[i].x, tbl[i].y, tbl[i].len, tbl[i].dead);
        end

        // Grow every tick to MAX_LEN and beyond; length must saturate at 16.
        step("turn_right_ov", L, L, H, RT, H, 208, 160, 5, L);
        for (int k = 1; k <= 12; k++) begin
            step($sformatf("grow_%0d", k), H, L, L, UP, H, 208 + 16 * k, 160,
                 (5 + k > 16) ? 16 : 5 + k, L);
        end
        for (int k = 1; k <= 14; k++) begin
            step($sformatf("to_wall_%0d", k), H, L, L, UP, L, 400 + 16 * k, 160, 16, L);
        end
        step("wall_right", H, L, L, UP, L, 624, 160, 16, H);
        step("dead_hold", H, L, L, UP, L, 624, 160, 16, H);
        step("dead_dir", L, L, H, DN, L, 624, 160, 16, H);
        step("dead_hold2", H, L, L, UP, H, 624, 160, 16, H);
        step("restart", L, H, L, UP, L, 144, 224, 3, L);

        // Top wall: y_bottom 0 stepping up underflows.
        step("turn_up", L, L, H, UP, L, 144, 224, 3, L);
        for (int k = 1; k <= 14; k++) begin
            step($sformatf("up_%0d", k), H, L, L, UP, L, 144, 224 - 16 * k, 3, L);
        end
        step("wall_top", H, L, L, UP, L, 144, 0, 3, H);
        step("restart2", L, H, L, UP, L, 144, 224, 3, L);

        // Length 5, turn down/left/up into its own body.
        step("sc_ov", L, L, L, UP, H, 144, 224, 3, L);
        step("sc_grow4", H, L, L, UP, H, 160, 224, 4, L);
        step("sc_grow5", H, L, L, UP, L, 176, 224, 5, L);
        step("sc_req_dn", L, L, H, DN, L, 176, 224, 5, L);
        step("sc_down", H, L, L, UP, L, 176, 240, 5, L);
        step("sc_req_lt", L, L, H, LT, L, 176, 240, 5, L);
        step("sc_left", H, L, L, UP, L, 160, 240, 5, L);
        step("sc_req_up", L, L, H, UP, L, 160, 240, 5, L);
        step("sc_bite", H, L, L, UP, L, 160, 240, 5, H);
        step("sc_hold", H, L, L, UP, L, 160, 240, 5, H);
        step("restart3", L, H, L, UP, L, 144, 224, 3, L);

        // Length 4 in a 2x2 loop: tail vacates, unless a grow is pending.
        step("lp_ov", L, L, L, UP, H, 144, 224, 3, L);
        step("lp_grow4", H, L, L, UP, L, 160, 224, 4, L);
        hit_check("tail_kept", 115, 230, H);
        hit_check("seg_len_unlit", 100, 230, L);
        hit_check("mid_seg", 130, 230, H);
        step("lp_req_dn", L, L, H, DN, L, 160, 224, 4, L);
        step("lp_down", H, L, L, UP, L, 160, 240, 4, L);
        step("lp_req_lt", L, L, H, LT, L, 160, 240, 4, L);
        step("lp_left", H, L, L, UP, L, 144, 240, 4, L);
        step("lp_req_up", L, L, H, UP, L, 144, 240, 4, L);
        step("lp_up", H, L, L, UP, L, 144, 224, 4, L);
        step("lp_req_rt", L, L, H, RT, L, 144, 224, 4, L);
        step("lp_right", H, L, L, UP, L, 160, 224, 4, L);
        step("lp_req_dn_ov", L, L, H, DN, H, 160, 224, 4, L);
        step("lp_grow_bite", H, L, L, UP, L, 160, 224, 4, H);
        step("restart4", L, H, L, UP, L, 144, 224, 3, L);

        // Pixel hit test around the start body.
        hit_check("hit_head", 150, 230, H);
        hit_check("miss_right", 160, 230, L);
        hit_check("hit_last_seg", 115, 230, H);
        hit_check("miss_seg_len", 100, 230, L);
        hit_check("miss_below", 150, 240, L);
        hit_check("hit_corner", 159, 239, H);

        // start wins over update/overlap in the same cycle.
        step("start_prio", H, H, L, UP, H, 144, 224, 3, L);
        step("after_prio", H, L, L, UP, L, 160, 224, 3, L);

        // Reset from RUN returns to IDLE at the start position.
        exp_q.push_back('{"reset_run", 144, 224, 3, L});
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        pop_check();
        @(negedge clk);
        rst_n = 1'b1;
        step("idle_after_rst", H, L, L, UP, L, 144, 224, 3, L);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
